// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bytes arrive over a valid/ready handshake; state, bit index and baud counter are
// exported for debug in the same form as the receiver.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        i_tx_valid,
  input  logic [7:0]  i8_tx_data,
  output logic        o_tx_ready,
  output logic        o_uart_tx,
  output logic        o_tx_done,
  output logic [7:0]  o8_uart_state,
  output logic [7:0]  o8_data_cnt,
  output logic [31:0] o32_sclk_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic [31:0] LastCnt  = 32'(CLKS_PER_BIT - 1);
  // Index of the final stop period; a single flop covers both legal stop-bit counts.
  localparam logic        LastStop = (STOP_BITS == 2);
  localparam logic        ParityEn = (PARITY != 0);
  localparam logic        ParityOdd = (PARITY == 1);

  state_e      state_q, state_d;
  logic [31:0] sclk_cnt_q, sclk_cnt_d;
  logic [2:0]  data_cnt_q, data_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        bit_end;

  assign bit_end = (sclk_cnt_q == LastCnt);

  // State and datapath registers; the line itself is a flop so it never glitches.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sclk_cnt_q <= '0;
      data_cnt_q <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_cnt_q <= sclk_cnt_d;
      data_cnt_q <= data_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: the line value for the next bit is decided together with the state.
  always_comb begin
    state_d    = state_q;
    sclk_cnt_d = sclk_cnt_q;
    data_cnt_d = data_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_cnt_d = '0;
        data_cnt_d = '0;
        stop_cnt_d = 1'b0;
        tx_d       = 1'b1;
        if (i_tx_valid) begin
          shreg_d = i8_tx_data;
          // Parity is fixed at accept time because the byte is shifted out afterwards.
          par_d   = ParityOdd ? ~(^i8_tx_data) : (^i8_tx_data);
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end

      StStart: begin
        if (bit_end) begin
          sclk_cnt_d = '0;
          data_cnt_d = '0;
          state_d    = StData;
          tx_d       = shreg_q[0];
        end else begin
          sclk_cnt_d = sclk_cnt_q + 32'd1;
        end
      end

      StData: begin
        if (bit_end) begin
          sclk_cnt_d = '0;
          if (data_cnt_q == 3'd7) begin
            data_cnt_d = '0;
            if (ParityEn) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d    = StStop;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            data_cnt_d = data_cnt_q + 3'd1;
            shreg_d    = {1'b0, shreg_q[7:1]};
            tx_d       = shreg_q[1];
          end
        end else begin
          sclk_cnt_d = sclk_cnt_q + 32'd1;
        end
      end

      StParity: begin
        if (bit_end) begin
          sclk_cnt_d = '0;
          state_d    = StStop;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end else begin
          sclk_cnt_d = sclk_cnt_q + 32'd1;
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          sclk_cnt_d = '0;
          if (stop_cnt_q == LastStop) begin
            stop_cnt_d = 1'b0;
            state_d    = StIdle;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          sclk_cnt_d = sclk_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d    = StIdle;
        sclk_cnt_d = '0;
        data_cnt_d = '0;
        stop_cnt_d = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign o_tx_ready    = (state_q == StIdle);
  assign o_uart_tx     = tx_q;
  assign o_tx_done     = done_q;
  assign o8_uart_state = {5'b0, state_q};
  assign o8_data_cnt   = {5'b0, data_cnt_q};
  assign o32_sclk_cnt  = sclk_cnt_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, even with two stop bits) share
// the stimulus; each has a frame-level reference model checked every cycle.
module tb_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int          NI  = 4;

  typedef struct packed {
    logic        line;
    logic [7:0]  st;
    logic [7:0]  dc;
    logic [31:0] sc;
  } exp_t;

  logic       sclk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       chk_on = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int unsigned PAR   = (g == 0) ? 0 : ((g == 2) ? 1 : 2);
    localparam int unsigned STOPS = (g == 3) ? 2 : 1;

    logic        line, ready, done;
    logic [7:0]  st, dc;
    logic [31:0] sc;

    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR),
      .STOP_BITS   (STOPS)
    ) u_dut (
      .sclk         (sclk),
      .rst          (rst),
      .i_tx_valid   (tx_valid),
      .i8_tx_data   (tx_data),
      .o_tx_ready   (ready),
      .o_uart_tx    (line),
      .o_tx_done    (done),
      .o8_uart_state(st),
      .o8_data_cnt  (dc),
      .o32_sclk_cnt (sc)
    );

    // Expected outputs for the cycle following each edge.
    exp_t q[$];
    exp_t cur;
    exp_t e;
    logic busy   = 1'b0;
    logic m_done = 1'b0;
    logic [7:0] d;

    // Reference model: on accept, lay out the whole frame cycle by cycle as a queue.
    initial begin
      cur = '{line: 1'b1, st: 8'd0, dc: 8'd0, sc: 32'd0};
      forever begin
        @(posedge sclk or posedge rst);
        m_done = 1'b0;
        if (rst) begin
          q.delete();
          busy = 1'b0;
          cur  = '{line: 1'b1, st: 8'd0, dc: 8'd0, sc: 32'd0};
        end else if (busy) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
          end else begin
            busy   = 1'b0;
            m_done = 1'b1;
            cur    = '{line: 1'b1, st: 8'd0, dc: 8'd0, sc: 32'd0};
          end
        end else if (tx_valid) begin
          d = tx_data;
          for (int s = 0; s < int'(CPB); s++) begin
            e = '{line: 1'b0, st: 8'd1, dc: 8'd0, sc: 32'(s)};
            q.push_back(e);
          end
          for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < int'(CPB); s++) begin
              e = '{line: d[b], st: 8'd2, dc: 8'(b), sc: 32'(s)};
              q.push_back(e);
            end
          end
          if (PAR != 0) begin
            for (int s = 0; s < int'(CPB); s++) begin
              e = '{line: (PAR == 2) ? (^d) : ~(^d), st: 8'd3, dc: 8'd0, sc: 32'(s)};
              q.push_back(e);
            end
          end
          for (int k = 0; k < int'(STOPS); k++) begin
            for (int s = 0; s < int'(CPB); s++) begin
              e = '{line: 1'b1, st: 8'd4, dc: 8'd0, sc: 32'(s)};
              q.push_back(e);
            end
          end
          busy = 1'b1;
          cur  = q.pop_front();
        end else begin
          cur = '{line: 1'b1, st: 8'd0, dc: 8'd0, sc: 32'd0};
        end
      end
    end

    // Compare every output against the model away from the active edge.
    initial begin
      forever begin
        @(negedge sclk);
        if (chk_on) begin
          check($sformatf("u%0d line", g), 32'(line), 32'(cur.line));
          check($sformatf("u%0d ready", g), 32'(ready), 32'(!busy));
          check($sformatf("u%0d done", g), 32'(done), 32'(m_done));
          check($sformatf("u%0d state", g), 32'(st), 32'(cur.st));
          check($sformatf("u%0d data_cnt", g), 32'(dc), 32'(cur.dc));
          check($sformatf("u%0d sclk_cnt", g), sc, cur.sc);
        end
      end
    end
  end

  logic [9:0] a5_bits;
  int         found;

  initial begin
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    a5_bits  = 10'b11_0100_1010;  // bit k of the vector is the k-th bit on the line

    // Asynchronous reset between edges takes effect with no clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst line", 32'(gen_dut[0].line), 32'd1);
    check("rst ready", 32'(gen_dut[0].ready), 32'd1);
    check("rst done", 32'(gen_dut[0].done), 32'd0);
    check("rst state", 32'(gen_dut[0].st), 32'd0);
    check("rst data_cnt", 32'(gen_dut[0].dc), 32'd0);
    check("rst sclk_cnt", gen_dut[0].sc, 32'd0);
    chk_on = 1'b1;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);

    // 0xA5 on the plain instance: fixed line pattern, 40 busy cycles, done in cycle 41.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge sclk);
    for (int c = 1; c <= 41; c++) begin
      @(negedge sclk);
      if (c == 1) tx_valid = 1'b0;
      if (c <= 40) check("a5 ready low", 32'(gen_dut[0].ready), 32'd0);
      if ((c % 4) == 2) check($sformatf("a5 bit%0d", (c - 1) / 4), 32'(gen_dut[0].line),
                              32'(a5_bits[(c - 1) / 4]));
      if (c == 41) check("a5 done", 32'(gen_dut[0].done), 32'd1);
    end
    repeat (20) @(negedge sclk);

    // 0x07: even parity bit 1, odd parity bit 0; frame lengths 44 and 48.
    tx_valid = 1'b1;
    tx_data  = 8'h07;
    @(posedge sclk);
    for (int c = 1; c <= 49; c++) begin
      @(negedge sclk);
      if (c == 1) tx_valid = 1'b0;
      if (c == 38) begin
        check("even parity", 32'(gen_dut[1].line), 32'd1);
        check("odd parity", 32'(gen_dut[2].line), 32'd0);
      end
      if (c == 45) check("par s1 done", 32'(gen_dut[1].done), 32'd1);
      if (c == 49) check("par s2 done", 32'(gen_dut[3].done), 32'd1);
    end
    repeat (10) @(negedge sclk);

    // Back-to-back 0x55 then 0xAA with valid held high.
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    found    = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge sclk);
      if (!gen_dut[0].ready) found = 1;
    end
    check("b2b accept1", 32'(found), 32'd1);
    tx_data = 8'hAA;
    found   = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge sclk);
      if (gen_dut[0].done) found = 1;
    end
    check("b2b done1", 32'(found), 32'd1);
    @(negedge sclk);
    check("b2b accept2", 32'(gen_dut[0].line), 32'd0);
    tx_valid = 1'b0;
    repeat (60) @(negedge sclk);

    // 0x3C while the data input churns every cycle.
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge sclk);
    tx_valid = 1'b0;
    repeat (60) begin
      tx_data = 8'($urandom);
      @(negedge sclk);
    end

    // Random traffic.
    repeat (1500) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      @(negedge sclk);
    end
    tx_valid = 1'b0;
    repeat (60) @(negedge sclk);

    // Reset during data bit 3: line high at once, no done pulse.
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    found    = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge sclk);
      if (gen_dut[0].dc == 8'd3) found = 1;
    end
    check("reach dcnt3", 32'(found), 32'd1);
    tx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid rst line", 32'(gen_dut[0].line), 32'd1);
    check("mid rst state", 32'(gen_dut[0].st), 32'd0);
    check("mid rst done", 32'(gen_dut[0].done), 32'd0);
    check("mid rst ready", 32'(gen_dut[0].ready), 32'd1);
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);

    // Clean 0xF0 frame after reset.
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    @(negedge sclk);
    tx_valid = 1'b0;
    repeat (70) @(negedge sclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
